frame_transmitter: RTL
======================

// Module: frame_transmitter
// PURPOSE
//  Avalon-MM-configured test-frame generator; drives the AXI-Stream ingress of frame_receptor.
//  Emits 16-bit-word frames: 3 preamble, 3 dst MAC, 3 src MAC, 1 ethertype, N payload words.
//  Payload pattern is deterministic, so a downstream payload checksum is predictable.
//  Supports single-shot or continuous generation, a programmable inter-frame gap, and abort.
// PARAMETERS
//  STUBBING            `STUBBING_PASSTHROUGH  PASSTHROUGH: egress_port_tvalid tied 0, regs still work
//  MAX_PAYLOAD_WORDS   750                    payload length clamp (words)
// PORTS
//  clk                  in   1   clock
//  reset                in   1   asynchronous, active-high reset
//  writedata            in   8   avalon_slave_0 write data
//  write                in   1   avalon write strobe
//  chipselect           in   1   avalon chipselect
//  address              in   8   avalon byte address
//  read                 in   1   avalon read strobe
//  readdata             out  8   avalon read data, registered
//  egress_port_tdata    out  16  stream data
//  egress_port_tvalid   out  1   stream valid
//  egress_port_tready   in   1   stream ready
//  egress_port_tlast    out  1   last word of frame
// BEHAVIOUR
//  Regs (R/W unless noted): 0-5 dst MAC b0..b5; 6-11 src MAC b0..b5; 12/13 ethertype lo/hi;
//   14/15 payload len (words) lo/hi, 0 treated as 1, >MAX clamped; 16 seed; 17 ctrl: b0 start
//   (self-clearing, reads 0), b1 continuous, b2 abort (self-clearing); 18 gap cycles;
//   19R status b0 busy, b1 abort pending; 20/21R frame count lo/hi; others read 0.
//  Reset: all regs 0, readdata 0, tvalid 0, tlast 0, tdata 0, FSM IDLE, count 0.
//   Async reset mid-frame: tvalid drops at once; no resumption.
//  Read: readdata valid the cycle after chipselect&&read; 0 when not reading.
//  Word order: 5555,5555,D555; {dst1,dst0},{dst3,dst2},{dst5,dst4}; same for src; {eth_hi,eth_lo};
//   payload[k] = ({seed,8'h00} + k) mod 2^16, k = 0..N-1; tlast only on payload[N-1].
//  FSM: IDLE -> PRE(3) -> DST(3) -> SRC(3) -> TYPE(1) -> PAY(N) -> GAP -> PRE (continuous) | IDLE.
//   Advance only on tvalid&&tready; tdata/tlast stable while tvalid&&!tready.
//   Start in IDLE: tvalid=1 with first preamble word on cycle after the write.
//   Start while busy: ignored. Config is shadowed at frame start; writes mid-frame affect next frame.
//   GAP: tvalid=0 for exactly gap cycles after tlast handshake (0 = next frame back-to-back).
//   Continuous cleared mid-frame: current frame completes, then IDLE.
//  Abort: flag set; current beat completes, then one beat tdata=0,tlast=1, then IDLE (no gap).
//   Abort in IDLE/GAP: GAP -> IDLE immediately; IDLE no effect. Abort frame still counted.
//  Frame count: +1 on each tlast handshake, 16-bit wrap (FFFF -> 0000).
// CONFIGURATION
//  FRAME_TX_CHECKSUM_EN defined: 32-bit sum of zero-extended payload words of last completed
//   frame, regs 24-27 (b0..b3), updated on tlast handshake, abort beat excluded.
//  Not defined: no accumulator; regs 24-27 read 0.
// TESTING
//  dst=01..06, len=1, seed=0, start, tready=1 -> 11 beats, beat3=0201,beat5=0605, beat10=0000 tlast.
//  len=4, seed=12, tready toggled every cycle -> payload 1200,1201,1202,1203 held stable while stalled.
//  continuous, len=2, gap=5 -> 5 idle cycles between tlast and next 5555; count increments each frame.
//  abort at payload beat 2 of len=8 -> next beat 0000 tlast, IDLE, busy=0, count=1.
//  CHECKSUM_EN, len=3, seed=FF -> regs 24-27 = 0002FD03 (FF00+FF01+FF02).
//  reset asserted mid-payload -> tvalid 0 same cycle, all regs read 0, next start is clean frame.

Source files
------------

// File: rtl/frame_transmitter.sv
// frame_transmitter
//   Test-frame generator configured over an 8-bit Avalon-MM slave. It drives a
//   16-bit AXI-Stream egress with frames made of 3 preamble words, 3 dst MAC
//   words, 3 src MAC words, 1 ethertype word and N payload words. The payload
//   is {seed,8'h00}+k, so anything downstream can predict it. Frames can be
//   sent one at a time or back to back with a programmable gap, and can be
//   aborted.
//
//   Build option: define FRAME_TX_CHECKSUM_EN to add a 32-bit payload sum of
//   the last completed frame, readable at regs 24..27. Without it, those regs
//   read 0.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   writedata/write/chipselect/address/read/readdata
//                         Avalon slave; readdata is registered and is 0 when
//                         no read is in progress
//   egress_port_tdata/tvalid/tready/tlast
//                         stream egress
module frame_transmitter #(
    parameter bit STUBBING          = 1'b0, // 1: tvalid held 0, registers still work
    parameter int MAX_PAYLOAD_WORDS = 750
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    output logic [15:0] egress_port_tdata,
    output logic        egress_port_tvalid,
    input  logic        egress_port_tready,
    output logic        egress_port_tlast
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_PAY, S_GAP, S_ABRT
    } state_t;

    // Live configuration (Avalon side)
    logic [5:0][7:0] dst_q, src_q;
    logic [15:0]     eth_q, len_q;
    logic [7:0]      seed_q, gap_q;
    logic            cont_q;

    // Per-frame copy so register writes mid-frame only affect the next frame
    logic [5:0][7:0] sh_dst_q, sh_src_q;
    logic [15:0]     sh_eth_q, sh_len_q;
    logic [7:0]      sh_seed_q;

    state_t      state_q;
    logic [15:0] beat_q, beat_d, count_q, tdata_q;
    logic [7:0]  gap_cnt_q, readdata_q, rd_mux;
    logic        tvalid_q, tlast_q, abort_q;

    logic        wr_en, start_wr, abort_wr, hs, abort_req, active, frame_end, do_load;
    logic [15:0] len_eff, last_beat;
    logic [2:0]  src_idx;

`ifdef FRAME_TX_CHECKSUM_EN
    logic [31:0] acc_q, csum_q;
`endif

    assign wr_en     = chipselect && write;
    assign start_wr  = wr_en && (address == 8'd17) && writedata[0];
    assign abort_wr  = wr_en && (address == 8'd17) && writedata[2];
    assign hs        = egress_port_tvalid && egress_port_tready;
    assign abort_req = abort_q || abort_wr;
    assign active    = (state_q == S_PRE) || (state_q == S_DST) || (state_q == S_SRC) ||
                       (state_q == S_TYPE) || (state_q == S_PAY);
    assign frame_end = active && hs && tlast_q;
    assign beat_d    = beat_q + 16'd1;
    assign last_beat = sh_len_q + 16'd9;
    // Regs 6..11 map to src bytes 0..5; the low 3 address bits minus 6 wrap correctly
    assign src_idx   = address[2:0] - 3'd6;

    // A new frame begins from IDLE on start, at the end of the gap, or straight
    // after tlast in continuous mode with a zero gap.
    assign do_load = ((state_q == S_IDLE) && start_wr) ||
                     ((state_q == S_GAP) && !abort_req && (gap_cnt_q <= 8'd1)) ||
                     (frame_end && !abort_req && cont_q && (gap_q == 8'd0));

    always_comb begin
        len_eff = len_q;
        if (len_q == 16'd0)
            len_eff = 16'd1;
        else if (len_q > MAX_LEN)
            len_eff = MAX_LEN;
    end

    function automatic logic [15:0] beat_word(input logic [15:0] b);
        logic [15:0] k;
        k = b - 16'd10;
        case (b)
            16'd0, 16'd1: beat_word = 16'h5555;
            16'd2:        beat_word = 16'hD555;
            16'd3:        beat_word = {sh_dst_q[1], sh_dst_q[0]};
            16'd4:        beat_word = {sh_dst_q[3], sh_dst_q[2]};
            16'd5:        beat_word = {sh_dst_q[5], sh_dst_q[4]};
            16'd6:        beat_word = {sh_src_q[1], sh_src_q[0]};
            16'd7:        beat_word = {sh_src_q[3], sh_src_q[2]};
            16'd8:        beat_word = {sh_src_q[5], sh_src_q[4]};
            16'd9:        beat_word = sh_eth_q;
            default:      beat_word = {sh_seed_q, 8'h00} + k;
        endcase
    endfunction

    function automatic state_t beat_state(input logic [15:0] b);
        if (b < 16'd3)       beat_state = S_PRE;
        else if (b < 16'd6)  beat_state = S_DST;
        else if (b < 16'd9)  beat_state = S_SRC;
        else if (b == 16'd9) beat_state = S_TYPE;
        else                 beat_state = S_PAY;
    endfunction

    // Register file writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_q  <= '0;
            src_q  <= '0;
            eth_q  <= '0;
            len_q  <= '0;
            seed_q <= '0;
            gap_q  <= '0;
            cont_q <= 1'b0;
        end else if (wr_en) begin
            if (address < 8'd6)
                dst_q[address[2:0]] <= writedata;
            else if (address < 8'd12)
                src_q[src_idx] <= writedata;
            else begin
                case (address)
                    8'd12:   eth_q[7:0]  <= writedata;
                    8'd13:   eth_q[15:8] <= writedata;
                    8'd14:   len_q[7:0]  <= writedata;
                    8'd15:   len_q[15:8] <= writedata;
                    8'd16:   seed_q      <= writedata;
                    8'd17:   cont_q      <= writedata[1];
                    8'd18:   gap_q       <= writedata;
                    default: ;
                endcase
            end
        end
    end

    // Frame FSM with registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            abort_q   <= 1'b0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            sh_dst_q  <= '0;
            sh_src_q  <= '0;
            sh_eth_q  <= '0;
            sh_len_q  <= 16'd1;
            sh_seed_q <= '0;
        end else begin
            // Abort only latches while a frame or gap is in progress
            if (abort_wr && (state_q != S_IDLE))
                abort_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                end
                S_GAP: begin
                    if (abort_req) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                S_ABRT: begin
                    if (hs) begin
                        count_q  <= count_q + 16'd1;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tdata_q  <= '0;
                        abort_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    if (hs) begin
                        if (tlast_q) begin
                            count_q  <= count_q + 16'd1;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tdata_q  <= '0;
                            if (abort_req) begin
                                state_q <= S_IDLE;
                                abort_q <= 1'b0;
                            end else if (cont_q) begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= gap_q;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else if (abort_req) begin
                            // Truncating beat: zero data with tlast
                            tdata_q <= '0;
                            tlast_q <= 1'b1;
                            state_q <= S_ABRT;
                        end else begin
                            beat_q  <= beat_d;
                            tdata_q <= beat_word(beat_d);
                            tlast_q <= (beat_d == last_beat);
                            state_q <= beat_state(beat_d);
                        end
                    end
                end
            endcase

            if (do_load) begin
                state_q   <= S_PRE;
                beat_q    <= '0;
                tdata_q   <= 16'h5555;
                tvalid_q  <= 1'b1;
                tlast_q   <= 1'b0;
                sh_dst_q  <= dst_q;
                sh_src_q  <= src_q;
                sh_eth_q  <= eth_q;
                sh_len_q  <= len_eff;
                sh_seed_q <= seed_q;
            end
        end
    end

`ifdef FRAME_TX_CHECKSUM_EN
    // Running payload sum; published on the closing handshake of each frame.
    // The abort beat carries no payload and is never added.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            if (hs && (state_q == S_PAY) && tlast_q)
                csum_q <= acc_q + {16'h0000, tdata_q};
            if (hs && (state_q == S_ABRT))
                csum_q <= acc_q;
            if (do_load)
                acc_q <= '0;
            else if (hs && (state_q == S_PAY))
                acc_q <= acc_q + {16'h0000, tdata_q};
        end
    end
`endif

    always_comb begin
        rd_mux = 8'h00;
        if (address < 8'd6)
            rd_mux = dst_q[address[2:0]];
        else if (address < 8'd12)
            rd_mux = src_q[src_idx];
        else begin
            case (address)
                8'd12:   rd_mux = eth_q[7:0];
                8'd13:   rd_mux = eth_q[15:8];
                8'd14:   rd_mux = len_q[7:0];
                8'd15:   rd_mux = len_q[15:8];
                8'd16:   rd_mux = seed_q;
                8'd17:   rd_mux = {6'b0, cont_q, 1'b0};
                8'd18:   rd_mux = gap_q;
                8'd19:   rd_mux = {6'b0, abort_q, (state_q != S_IDLE)};
                8'd20:   rd_mux = count_q[7:0];
                8'd21:   rd_mux = count_q[15:8];
`ifdef FRAME_TX_CHECKSUM_EN
                8'd24:   rd_mux = csum_q[7:0];
                8'd25:   rd_mux = csum_q[15:8];
                8'd26:   rd_mux = csum_q[23:16];
                8'd27:   rd_mux = csum_q[31:24];
`endif
                default: rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata_q <= '0;
        else if (chipselect && read)
            readdata_q <= rd_mux;
        else
            readdata_q <= '0;
    end

    assign readdata           = readdata_q;
    assign egress_port_tdata  = tdata_q;
    assign egress_port_tlast  = tlast_q;
    assign egress_port_tvalid = STUBBING ? 1'b0 : tvalid_q;

endmodule
